// File: rtl/adc_capture_gate.sv
// ---------------------------------------------------------------------------
// adc_capture_gate
//   Per-channel trigger/capture gate between an ADC AXI4-Stream and its
//   readout buffer stream. After an arm pulse the gate waits for a trigger.
//   It then forwards exactly len accepted beats through a single output
//   register and marks the final beat with tlast. A beat that arrives while
//   the output register is still held by the buffer is dropped and flagged
//   in overflow. The ADC side is never stalled.
//
//   Optional feature macro: THRESH_TRIG_EN
//     When defined, an armed gate also triggers on any input beat that holds
//     a signed sample above `threshold`. When undefined, no comparator is
//     built and only sw_trig can trigger.
// ---------------------------------------------------------------------------
module adc_capture_gate #(
  parameter int ADC_WIDTH = 128,
  parameter int NSAMP     = 8,
  parameter int LEN_BITS  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ADC_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [ADC_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 sw_trig,
  input  logic [LEN_BITS-1:0]  capture_len,
  input  logic [15:0]          threshold,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   count_q, count_d;
  logic [ADC_WIDTH-1:0]  tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic                  trig_hit;
  logic                  can_load;
  logic                  capture_beat;

  // The ADC is never back-pressured; beats that cannot be loaded are dropped.
  assign s_axis_tready = 1'b1;

  // The output register accepts a new beat when empty or draining this cycle.
  assign can_load = !tvalid_q || m_axis_tready;

`ifdef THRESH_TRIG_EN
  logic thresh_hit;

  // Any signed sample of the current input beat above the threshold.
  always_comb begin
    thresh_hit = 1'b0;
    for (int i = 0; i < NSAMP; i++) begin
      if ($signed(s_axis_tdata[i*16 +: 16]) > $signed(threshold)) begin
        thresh_hit = 1'b1;
      end
    end
  end

  assign trig_hit = sw_trig || thresh_hit;
`else
  // Threshold is not used in this build; fold it into a sink signal.
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign trig_hit         = sw_trig;
`endif

  // Next-state, capture and output-register control.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    capture_beat = 1'b0;

    // A held beat leaves once the buffer takes it; tdata may keep its value.
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (abort) begin
      // Abort wins over arm, trigger and load. A held beat still drains.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d    = S_ARMED;
            len_d      = (capture_len == '0) ? LEN_BITS'(1) : capture_len;
            count_d    = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
          end
        end
        S_ARMED: begin
          // The triggering beat is itself the first captured beat.
          if (s_axis_tvalid && trig_hit) begin
            state_d      = S_CAPTURE;
            capture_beat = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (s_axis_tvalid) begin
            capture_beat = 1'b1;
          end
        end
        S_DONE: begin
          if (tvalid_q && tlast_q && m_axis_tready) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Load the beat if the register has room, otherwise drop it. The count
    // only advances on a load, so the buffer always sees exactly len beats.
    if (capture_beat) begin
      if (can_load) begin
        tdata_d  = s_axis_tdata;
        tvalid_d = 1'b1;
        count_d  = count_q + LEN_BITS'(1);
        if (count_q == len_q - LEN_BITS'(1)) begin
          tlast_d = 1'b1;
          state_d = S_DONE;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the data register is reset too, so m_axis_tdata reads zero out
      // of reset instead of X; downstream logic may observe it directly.
      state_q    <= S_IDLE;
      len_q      <= LEN_BITS'(1);
      count_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule
